// File: rtl/ddr2_cmd_seq.sv
// DDR2 SODIMM command sequencer: JEDEC power-up/MRS sequence, close-page ACT + RDA/WRA
// per single-beat request, and periodic auto-refresh. All DIMM pins and strobes are registered.
module ddr2_cmd_seq #(
  parameter int          T_INIT    = 40000,
  parameter int          T_CKE     = 80,
  parameter int          T_RP      = 3,
  parameter int          T_MRD     = 2,
  parameter int          T_RFC     = 21,
  parameter int          T_RCD     = 3,
  parameter int          T_RD_DONE = 8,
  parameter int          T_WR_DONE = 12,
  parameter int          T_REFI    = 1560,
  parameter logic [12:0] MR_VAL    = 13'h0432,
  parameter logic [12:0] EMR_VAL   = 13'h0004
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [24:0] i_req_addr,
  output logic        o_rd_issue,
  output logic        o_wr_issue,
  output logic        o_init_done,
  output logic        o_ddr_cke,
  output logic        o_ddr_cs_n,
  output logic        o_ddr_ras_n,
  output logic        o_ddr_cas_n,
  output logic        o_ddr_we_n,
  output logic [1:0]  o_ddr_ba,
  output logic [12:0] o_ddr_addr
);

  localparam int CNT_W  = $clog2(T_INIT + T_CKE + T_RFC + T_WR_DONE + T_RD_DONE + 2);
  localparam int REFI_W = $clog2(T_REFI + 1);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_PREA, S_EMR2, S_EMR3, S_EMR1, S_MR_DLL, S_PREA2,
    S_REF1, S_REF2, S_MR, S_IDLE, S_RW, S_WAIT
  } state_t;

  state_t              r_state, r_ret;
  logic [CNT_W-1:0]    r_cnt;
  logic [REFI_W-1:0]   r_refi;
  logic                r_ref_pend;
  logic                r_we;
  logic [1:0]          r_ba_l;
  logic [9:0]          r_col;
  logic                r_cke, r_cs_n, r_rd, r_wr, r_req_ready, r_init_done;
  logic [2:0]          r_cmd;
  logic [1:0]          r_ba;
  logic [12:0]         r_addr;

  state_t              w_cur, w_state_nxt, w_ret_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [2:0]          w_cmd;
  logic                w_cke, w_cs_n, w_rd, w_wr;
  logic [1:0]          w_ba;
  logic [12:0]         w_addr;
  logic                w_ref_clr, w_accept, w_idle_nxt, w_expire, w_ref_pend_nxt;

  // A WAIT that hits zero acts as its return state in the same cycle, so command spacing equals T_x.
  always_comb begin
    w_cur       = (r_state == S_WAIT && r_cnt == '0) ? r_ret : r_state;
    w_state_nxt = w_cur;
    w_ret_nxt   = r_ret;
    w_cnt_nxt   = r_cnt;
    w_cmd       = CMD_NOP;
    w_cke       = 1'b1;
    w_cs_n      = 1'b0;
    w_ba        = 2'd0;
    w_addr      = 13'd0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_ref_clr   = 1'b0;
    w_accept    = 1'b0;
    case (w_cur)
      S_INIT_WAIT: begin
        w_cke  = 1'b0;
        w_cs_n = 1'b1;
        if (r_cnt == CNT_W'(T_INIT - 1)) begin
          w_cke       = 1'b1;
          w_cs_n      = 1'b0;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(T_CKE - 1);
          w_ret_nxt   = S_PREA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PREA, S_PREA2: begin
        w_cmd       = CMD_PRE;
        w_addr      = 13'h0400;
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = CNT_W'(T_RP - 1);
        w_ret_nxt   = (w_cur == S_PREA) ? S_EMR2 : S_REF1;
      end
      S_EMR2, S_EMR3, S_EMR1, S_MR_DLL, S_MR: begin
        w_cmd       = CMD_MRS;
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = CNT_W'(T_MRD - 1);
        case (w_cur)
          S_EMR2:   begin w_ba = 2'd2; w_ret_nxt = S_EMR3; end
          S_EMR3:   begin w_ba = 2'd3; w_ret_nxt = S_EMR1; end
          S_EMR1:   begin w_ba = 2'd1; w_addr = EMR_VAL; w_ret_nxt = S_MR_DLL; end
          S_MR_DLL: begin w_addr = MR_VAL | 13'h0100; w_ret_nxt = S_PREA2; end
          default:  begin w_addr = MR_VAL; w_ret_nxt = S_IDLE; end
        endcase
      end
      S_REF1, S_REF2: begin
        w_cmd       = CMD_REF;
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = CNT_W'(T_RFC - 1);
        w_ret_nxt   = (w_cur == S_REF1) ? S_REF2 : S_MR;
      end
      S_IDLE: begin
        w_state_nxt = S_IDLE;
        if (r_ref_pend) begin
          w_cmd       = CMD_REF;
          w_ref_clr   = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(T_RFC - 1);
          w_ret_nxt   = S_IDLE;
        end else if (r_req_ready && i_req_valid) begin
          w_accept    = 1'b1;
          w_cmd       = CMD_ACT;
          w_ba        = i_req_addr[24:23];
          w_addr      = i_req_addr[22:10];
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(T_RCD - 1);
          w_ret_nxt   = S_RW;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RW: begin
        w_cmd       = r_we ? CMD_WR : CMD_RD;
        w_ba        = r_ba_l;
        w_addr      = {2'b00, 1'b1, r_col};
        w_rd        = ~r_we;
        w_wr        = r_we;
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = r_we ? CNT_W'(T_WR_DONE - 1) : CNT_W'(T_RD_DONE - 1);
        w_ret_nxt   = S_IDLE;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      default: begin
        w_state_nxt = S_INIT_WAIT;
      end
    endcase
    // req_ready is registered, so it is raised the cycle before the FSM will sit in IDLE
    w_idle_nxt = (w_state_nxt == S_IDLE) ||
                 (w_state_nxt == S_WAIT && w_cnt_nxt == '0 && w_ret_nxt == S_IDLE);
  end

  always_comb begin
    w_expire       = r_init_done && (r_refi == REFI_W'(T_REFI - 1));
    w_ref_pend_nxt = w_expire || (r_ref_pend && !w_ref_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_INIT_WAIT;
      r_ret       <= S_INIT_WAIT;
      r_cnt       <= '0;
      r_refi      <= '0;
      r_ref_pend  <= 1'b0;
      r_we        <= 1'b0;
      r_ba_l      <= 2'd0;
      r_col       <= 10'd0;
      r_cke       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_cmd       <= CMD_NOP;
      r_ba        <= 2'd0;
      r_addr      <= 13'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ret      <= w_ret_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ref_pend <= w_ref_pend_nxt;
      if (w_expire) begin
        r_refi <= '0;
      end else if (r_init_done) begin
        r_refi <= r_refi + REFI_W'(1);
      end
      if (w_accept) begin
        r_we   <= i_req_we;
        r_ba_l <= i_req_addr[24:23];
        r_col  <= i_req_addr[9:0];
      end
      r_cke       <= w_cke;
      r_cs_n      <= w_cs_n;
      r_cmd       <= w_cmd;
      r_ba        <= w_ba;
      r_addr      <= w_addr;
      r_rd        <= w_rd;
      r_wr        <= w_wr;
      r_req_ready <= w_idle_nxt && !w_ref_pend_nxt;
      r_init_done <= r_init_done || w_idle_nxt;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rd_issue  = r_rd;
  assign o_wr_issue  = r_wr;
  assign o_init_done = r_init_done;
  assign o_ddr_cke   = r_cke;
  assign o_ddr_cs_n  = r_cs_n;
  assign o_ddr_ras_n = r_cmd[2];
  assign o_ddr_cas_n = r_cmd[1];
  assign o_ddr_we_n  = r_cmd[0];
  assign o_ddr_ba    = r_ba;
  assign o_ddr_addr  = r_addr;

endmodule

// File: tb/tb_ddr2_cmd_seq.sv
// Self-checking bench for ddr2_cmd_seq: a timeline model predicts every pin each cycle,
// plus hand-computed literals for the init sequence, a write/read pair and mid-operation reset.
module tb_ddr2_cmd_seq;
  localparam int T_INIT = 10, T_CKE = 4, T_RP = 3, T_MRD = 2, T_RFC = 21, T_RCD = 3;
  localparam int T_RD_DONE = 8, T_WR_DONE = 12, T_REFI = 200;
  localparam logic [12:0] MR_VAL = 13'h0432, EMR_VAL = 13'h0004;
  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
  localparam logic [2:0] PRE = 3'b010, REF = 3'b001, MRS = 3'b000;

  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0;
  logic [24:0] req_addr = 25'd0;
  logic req_ready, rd_issue, wr_issue, init_done, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0] ba;
  logic [12:0] addr;

  always #5 clk = ~clk;

  ddr2_cmd_seq #(.T_INIT(T_INIT), .T_CKE(T_CKE), .T_RP(T_RP), .T_MRD(T_MRD), .T_RFC(T_RFC),
                 .T_RCD(T_RCD), .T_RD_DONE(T_RD_DONE), .T_WR_DONE(T_WR_DONE), .T_REFI(T_REFI),
                 .MR_VAL(MR_VAL), .EMR_VAL(EMR_VAL)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .o_rd_issue(rd_issue), .o_wr_issue(wr_issue),
    .o_init_done(init_done), .o_ddr_cke(cke), .o_ddr_cs_n(cs_n), .o_ddr_ras_n(ras_n),
    .o_ddr_cas_n(cas_n), .o_ddr_we_n(we_n), .o_ddr_ba(ba), .o_ddr_addr(addr));

  int errors = 0, checks = 0;
  // Model: n counts cycles since the last reset edge; expected commands live on a timeline.
  int n, d_at, idle_at, next_ref, first_cke;
  bit pend, armed = 1'b0;
  logic [2:0]  e_cmd [int];
  logic [14:0] e_val [int];
  logic [14:0] e_mask[int];
  typedef struct { int n; logic [2:0] cmd; logic [1:0] ba; logic [12:0] addr; } ev_t;
  ev_t log_q[$];

  task automatic sched(input int t, input logic [2:0] c, input logic [14:0] v, input logic [14:0] m);
    e_cmd[t] = c; e_val[t] = v; e_mask[t] = m;
  endtask

  task automatic model_reset();
    int t;
    n = 0; pend = 1'b0; first_cke = -1;
    e_cmd.delete(); e_val.delete(); e_mask.delete(); log_q.delete();
    t = T_INIT + T_CKE;  sched(t, PRE, 15'h0400, 15'h0400);
    t += T_RP;           sched(t, MRS, {2'd2, 13'h0000}, 15'h7fff);
    t += T_MRD;          sched(t, MRS, {2'd3, 13'h0000}, 15'h7fff);
    t += T_MRD;          sched(t, MRS, {2'd1, EMR_VAL}, 15'h7fff);
    t += T_MRD;          sched(t, MRS, {2'd0, MR_VAL | 13'h0100}, 15'h7fff);
    t += T_MRD;          sched(t, PRE, 15'h0400, 15'h0400);
    t += T_RP;           sched(t, REF, 15'h0, 15'h0);
    t += T_RFC;          sched(t, REF, 15'h0, 15'h0);
    t += T_RFC;          sched(t, MRS, {2'd0, MR_VAL}, 15'h7fff);
    d_at = t + T_MRD - 1;
    idle_at = d_at;
    next_ref = d_at + T_REFI;
  endtask

  task automatic tick();
    logic [2:0] a_cmd, x_cmd;
    logic [8:0] a_v, x_v;
    logic [14:0] x_val, x_mask;
    bit ok;
    @(negedge clk);
    if (armed) begin
      if (n == next_ref) begin pend = 1'b1; next_ref += T_REFI; end
      a_cmd  = {ras_n, cas_n, we_n};
      x_cmd  = e_cmd.exists(n) ? e_cmd[n] : NOP;
      x_val  = e_val.exists(n) ? e_val[n] : 15'h0;
      x_mask = e_mask.exists(n) ? e_mask[n] : 15'h0;
      x_v = {n >= T_INIT, n < T_INIT, x_cmd, x_cmd == RD, x_cmd == WR,
             (n >= idle_at) && !pend, n >= d_at};
      a_v = {cke, cs_n, a_cmd, rd_issue, wr_issue, req_ready, init_done};
      ok = (a_v === x_v) && ((({ba, addr} ^ x_val) & x_mask) == 15'h0);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pins n=%0d: got cke/cs/cmd/rd/wr/rdy/done=%b ba_addr=%h, expected %b ba_addr=%h mask=%h",
                 n, a_v, {ba, addr}, x_v, x_val, x_mask);
      end
      if (!cs_n && a_cmd != NOP) log_q.push_back('{n, a_cmd, ba, addr});
      if (cke && first_cke < 0) first_cke = n;
    end
  endtask

  task automatic drive(input bit v, input bit w, input logic [24:0] a, input bit r);
    req_valid = v; req_we = w; req_addr = a; rst = r;
  endtask

  task automatic adv();
    if (rst) begin
      model_reset();
      armed = 1'b1;
    end else begin
      if (n >= idle_at) begin
        if (pend) begin
          sched(n + 1, REF, 15'h0, 15'h0);
          pend = 1'b0;
          idle_at = n + T_RFC;
        end else if (req_valid) begin
          sched(n + 1, ACT, {req_addr[24:23], req_addr[22:10]}, 15'h7fff);
          sched(n + 1 + T_RCD, req_we ? WR : RD, {req_addr[24:23], 2'b00, 1'b1, req_addr[9:0]}, 15'h7fff);
          idle_at = n + T_RCD + (req_we ? T_WR_DONE : T_RD_DONE);
        end
      end
      n++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input string name, input int idx, input int en, input logic [2:0] ec,
                        input logic [1:0] eb, input logic [12:0] ea);
    if (log_q.size() > idx) begin
      chk({name, "_cycle"}, log_q[idx].n, en);
      chk({name, "_cmd_ba_addr"}, {log_q[idx].cmd, log_q[idx].ba, log_q[idx].addr}, {ec, eb, ea});
    end else begin
      chk({name, "_present"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    logic [24:0] w1, r1;
    bit wr_acc, rd_acc, got_act;
    int refs;
    w1 = {2'd2, 13'h1ABC, 10'h155};
    r1 = {2'd1, 13'h0F0F, 10'h2AA};
    repeat (3) begin tick(); drive(1'b0, 1'b0, 25'd0, 1'b1); adv(); end

    // Init with a request held valid throughout, then a back-to-back write and read
    wr_acc = 1'b0; rd_acc = 1'b0;
    repeat (120) begin
      tick();
      if (!wr_acc) begin
        drive(1'b1, 1'b1, w1, 1'b0); wr_acc = req_ready;
      end else if (!rd_acc) begin
        drive(1'b1, 1'b0, r1, 1'b0); rd_acc = req_ready;
      end else begin
        drive(1'b0, 1'b0, 25'd0, 1'b0);
      end
      adv();
    end
    chk("cke_low_clks", first_cke, 10);
    chk_ev("prea1", 0, 14, PRE, 2'd0, 13'h0400);
    chk_ev("emr2", 1, 17, MRS, 2'd2, 13'h0000);
    chk_ev("emr1", 3, 21, MRS, 2'd1, 13'h0004);
    chk_ev("mr_dll", 4, 23, MRS, 2'd0, 13'h0532);
    chk_ev("ref2", 7, 49, REF, 2'd0, 13'h0000);
    chk_ev("mr_final", 8, 70, MRS, 2'd0, 13'h0432);
    chk_ev("act_wr", 9, 72, ACT, 2'd2, 13'h1ABC);
    chk_ev("wra", 10, 75, WR, 2'd2, 13'h0555);
    chk_ev("act_rd", 11, 87, ACT, 2'd1, 13'h0F0F);
    chk_ev("rda", 12, 90, RD, 2'd1, 13'h06AA);

    // Random traffic across several refresh intervals
    repeat (1500) begin
      tick();
      drive($urandom_range(0, 99) < 75, 1'($urandom_range(0, 1)), 25'($urandom), 1'b0);
      adv();
    end
    refs = 0;
    foreach (log_q[i]) if (i > 8 && log_q[i].cmd == REF) refs++;
    chk("refreshes_seen_ge6", int'(refs >= 6), 1);

    // Reset the cycle an ACT is on the pins: no RDA/WRA may follow
    got_act = 1'b0;
    for (int k = 0; k < 400 && !got_act; k++) begin
      tick();
      if (!cs_n && {ras_n, cas_n, we_n} == ACT) begin
        got_act = 1'b1;
        drive(1'b0, 1'b0, 25'd0, 1'b1);
      end else begin
        drive(1'b1, 1'($urandom_range(0, 1)), 25'($urandom), 1'b0);
      end
      adv();
    end
    chk("act_before_reset_found", int'(got_act), 1);
    tick(); drive(1'b1, 1'b1, w1, 1'b0); adv();
    repeat (100) begin tick(); drive(1'b1, 1'b0, r1, 1'b0); adv(); end
    chk_ev("reinit_mr_final", 8, 70, MRS, 2'd0, 13'h0432);
    chk_ev("reinit_first_act", 9, 72, ACT, 2'd1, 13'h0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
